// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
//
// Purpose: bundles every non-clock signal of the R-type issue/writeback
// sequencer into one interface. The interface carries three groups of signals:
// the instruction handshake, the register-file read/write ports and the ALU
// operand/result ports. It also carries the retirement status.
//
// Modports:
//   slave  - the sequencer (alu_issue_ctrl). It accepts instructions, drives
//            the register-file addresses and ALU operands, and consumes the ALU
//            result and the register-file read data.
//   master - the surrounding environment: instruction source, register file
//            and ALU.
//
// Signals:
//   inst[31:0]        instruction word (op/rs/rt/rd/funct fields)
//   inst_valid        inst is valid
//   inst_ready        sequencer can accept an instruction
//   rf_raddr1/2[4:0]  register-file read addresses (rs, rt)
//   rf_rdata1/2[31:0] combinational register-file read data
//   rf_we             register-file write enable (one-cycle pulse)
//   rf_waddr[4:0]     write address (rd)
//   rf_wdata[31:0]    write data
//   alu_a/alu_b[31:0] ALU operands
//   alu_op[2:0]       ALU operation code
//   alu_f[31:0]       ALU result
//   alu_zf, alu_of    ALU zero / overflow flags
//   zf, of            flags of the last completed instruction
//   done              one-cycle retirement pulse
//   illegal           one-cycle pulse with done for an undecodable instruction
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;

  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_f;
  logic        alu_zf;
  logic        alu_of;

  logic        zf;
  logic        of;
  logic        done;
  logic        illegal;

  modport slave (
    input  inst, inst_valid,
    input  rf_rdata1, rf_rdata2,
    input  alu_f, alu_zf, alu_of,
    output inst_ready,
    output rf_raddr1, rf_raddr2,
    output rf_we, rf_waddr, rf_wdata,
    output alu_a, alu_b, alu_op,
    output zf, of, done, illegal
  );

  modport master (
    output inst, inst_valid,
    output rf_rdata1, rf_rdata2,
    output alu_f, alu_zf, alu_of,
    input  inst_ready,
    input  rf_raddr1, rf_raddr2,
    input  rf_we, rf_waddr, rf_wdata,
    input  alu_a, alu_b, alu_op,
    input  zf, of, done, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose: multi-cycle issue/writeback sequencer for the R-type CPU.
// It accepts one instruction at a time and walks IDLE -> READ -> EXEC -> WB.
// In READ it reads rs/rt from the register file. In EXEC it drives the
// combinational ALU. In WB it writes the captured result back to rd.
// One instruction is retired every four cycles.
//
// Ports:
//   clk     single clock, all state updates on the rising edge
//   rst     synchronous active-high reset; aborts any instruction in flight
//   bus_io  alu_issue_ctrl_if.slave - handshake, register file, ALU, status
//
// Build option:
//   ALU_ISSUE_OVF_TRAP_EN - when defined, an ADD/SUB whose captured overflow
//   flag is set does not write back. When undefined, overflowing results are
//   written normally. In both builds, `of` reports the overflow.
// -----------------------------------------------------------------------------
module alu_issue_ctrl (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus_io
);

  // funct encodings of the supported R-type operations
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // Instruction register and datapath registers
  logic [31:0] ir_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] r_q;
  logic        zf_q;
  logic        of_q;

  // Registers that hold the last driven value of outputs that only change in
  // one state (ALU opcode and register-file read addresses)
  logic [2:0]  alu_op_q;
  logic [4:0]  raddr1_q;
  logic [4:0]  raddr2_q;

  // IR fields
  logic [5:0]  ir_op;
  logic [4:0]  ir_rs;
  logic [4:0]  ir_rt;
  logic [4:0]  ir_rd;
  logic [5:0]  ir_funct;

  assign ir_op    = ir_q[31:26];
  assign ir_rs    = ir_q[25:21];
  assign ir_rt    = ir_q[20:16];
  assign ir_rd    = ir_q[15:11];
  assign ir_funct = ir_q[5:0];

  // The shamt field is not used by any supported operation
  logic unused_shamt;
  assign unused_shamt = ^ir_q[10:6];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       dec_legal;
  logic [2:0] dec_op;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 3'b000;
    if (ir_op == 6'b000000) begin
      dec_legal = 1'b1;
      case (ir_funct)
        FN_AND:  dec_op = 3'b000;
        FN_OR:   dec_op = 3'b001;
        FN_XOR:  dec_op = 3'b010;
        FN_NOR:  dec_op = 3'b011;
        FN_ADD:  dec_op = 3'b100;
        FN_SUB:  dec_op = 3'b101;
        FN_SLT:  dec_op = 3'b110;
        FN_SLLV: dec_op = 3'b111;
        default: begin
          dec_legal = 1'b0;
          dec_op    = 3'b000;
        end
      endcase
    end
  end

  // An overflowing ADD/SUB is squashed only in the trapping build. In that
  // build, it is never reported as illegal.
  logic ovf_trap;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  assign ovf_trap = dec_legal & of_q &
                    ((ir_funct == FN_ADD) | (ir_funct == FN_SUB));
`else
  assign ovf_trap = 1'b0;
`endif

  logic wb_write;
  assign wb_write = dec_legal & (ir_rd != 5'd0) & ~ovf_trap;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_io.inst_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_io.inst_ready = 1'b0;
    bus_io.done       = 1'b0;
    bus_io.illegal    = 1'b0;
    bus_io.rf_we      = 1'b0;
    bus_io.rf_raddr1  = raddr1_q;
    bus_io.rf_raddr2  = raddr2_q;
    bus_io.rf_waddr   = ir_rd;
    bus_io.rf_wdata   = r_q;
    // A_q/B_q change only at the end of READ. Driving them directly means that
    // the operands hold their EXEC values everywhere else.
    bus_io.alu_a      = a_q;
    bus_io.alu_b      = b_q;
    bus_io.alu_op     = alu_op_q;
    bus_io.zf         = zf_q;
    bus_io.of         = of_q;
    case (state_q)
      IDLE: bus_io.inst_ready = 1'b1;
      READ: begin
        bus_io.rf_raddr1 = ir_rs;
        bus_io.rf_raddr2 = ir_rt;
      end
      WB: begin
        // A reset that lands in WB aborts the retirement in the same cycle,
        // so no write or done pulse leaks out.
        if (!rst) begin
          bus_io.done    = 1'b1;
          bus_io.illegal = ~dec_legal;
          bus_io.rf_we   = wb_write;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      zf_q     <= 1'b0;
      of_q     <= 1'b0;
      alu_op_q <= 3'b000;
      raddr1_q <= '0;
      raddr2_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_io.inst_valid) ir_q <= bus_io.inst;
        end
        READ: begin
          a_q      <= bus_io.rf_rdata1;
          b_q      <= bus_io.rf_rdata2;
          raddr1_q <= ir_rs;
          raddr2_q <= ir_rt;
          // IR is stable from acceptance, so the opcode can be registered here
          // and presented for the whole of EXEC.
          alu_op_q <= dec_op;
        end
        EXEC: begin
          r_q  <= bus_io.alu_f;
          zf_q <= bus_io.alu_zf;
          of_q <= bus_io.alu_of;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

`ifdef ALU_ISSUE_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // ---------------- environment: register file ----------------
  logic [31:0] mem [32];
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (bus.rf_we && bus.rf_waddr != 5'd0) mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  assign bus.rf_rdata1 = (bus.rf_raddr1 == 5'd0) ? 32'd0 : mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = (bus.rf_raddr2 == 5'd0) ? 32'd0 : mem[bus.rf_raddr2];

  // ---------------- environment: combinational ALU ----------------
  logic [31:0] alu_f_m;
  logic        alu_of_m;
  always_comb begin
    alu_f_m  = 32'd0;
    alu_of_m = 1'b0;
    case (bus.alu_op)
      3'd0: alu_f_m = bus.alu_a & bus.alu_b;
      3'd1: alu_f_m = bus.alu_a | bus.alu_b;
      3'd2: alu_f_m = bus.alu_a ^ bus.alu_b;
      3'd3: alu_f_m = ~(bus.alu_a | bus.alu_b);
      3'd4: begin
        alu_f_m  = bus.alu_a + bus.alu_b;
        alu_of_m = (bus.alu_a[31] == bus.alu_b[31]) && (alu_f_m[31] != bus.alu_a[31]);
      end
      3'd5: begin
        alu_f_m  = bus.alu_a - bus.alu_b;
        alu_of_m = (bus.alu_a[31] != bus.alu_b[31]) && (alu_f_m[31] != bus.alu_a[31]);
      end
      3'd6: alu_f_m = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: alu_f_m = bus.alu_b << bus.alu_a[4:0];
    endcase
  end
  assign bus.alu_f  = alu_f_m;
  assign bus.alu_zf = (alu_f_m == 32'd0);
  assign bus.alu_of = alu_of_m;

  // ---------------- reference model ----------------
  logic [31:0] ref_regs [32];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  // Instruction semantics from the funct field, using plain arithmetic.
  function automatic void ref_exec(input logic [31:0] ins, input logic [31:0] ra,
                                   input logic [31:0] rb, output logic [31:0] res,
                                   output logic z, output logic o, output logic legal,
                                   output logic [2:0] code, output logic addsub);
    longint s;
    legal = 1'b1; addsub = 1'b0; o = 1'b0; code = 3'd0; res = 32'd0;
    if (ins[31:26] != 6'd0) legal = 1'b0;
    else begin
      case (ins[5:0])
        6'h24: begin code = 3'd0; res = ra & rb; end
        6'h25: begin code = 3'd1; res = ra | rb; end
        6'h26: begin code = 3'd2; res = ra ^ rb; end
        6'h27: begin code = 3'd3; res = ~(ra | rb); end
        6'h20: begin
          code = 3'd4; addsub = 1'b1; res = ra + rb;
          s = longint'($signed(ra)) + longint'($signed(rb));
          o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        6'h22: begin
          code = 3'd5; addsub = 1'b1; res = ra - rb;
          s = longint'($signed(ra)) - longint'($signed(rb));
          o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        6'h2a: begin code = 3'd6; res = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0; end
        6'h04: begin code = 3'd7; res = rb << ra[4:0]; end
        default: legal = 1'b0;
      endcase
    end
    // An undecodable instruction still runs the ALU with opcode 000 (AND).
    if (!legal) begin code = 3'd0; res = ra & rb; o = 1'b0; end
    z = (res == 32'd0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    ref_regs[a] = d;
  endtask

  // Issues one instruction in IDLE and checks every state up to the next IDLE.
  task automatic issue(input logic [31:0] ins, input bit keep_valid, input string name);
    logic [31:0] ra, rb, res;
    logic        z, o, legal, addsub, exp_we;
    logic [2:0]  code;
    logic [4:0]  rs, rt, rd;
    int          w;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    ra = (rs == 5'd0) ? 32'd0 : ref_regs[rs];
    rb = (rt == 5'd0) ? 32'd0 : ref_regs[rt];
    ref_exec(ins, ra, rb, res, z, o, legal, code, addsub);
    exp_we = legal && (rd != 5'd0) && !(TRAP_EN && addsub && o);

    w = 0;
    while (!bus.inst_ready && w < 8) begin tick(); w++; end
    check({name, "_idle_ready"}, 32'(bus.inst_ready), 32'd1);
    bus.inst = ins; bus.inst_valid = 1'b1;
    tick();                                   // READ
    bus.inst = $urandom; bus.inst_valid = keep_valid;
    check({name, "_read_ready"}, 32'(bus.inst_ready), 32'd0);
    check({name, "_raddr1"}, 32'(bus.rf_raddr1), 32'(rs));
    check({name, "_raddr2"}, 32'(bus.rf_raddr2), 32'(rt));
    check({name, "_read_done"}, 32'(bus.done), 32'd0);
    tick();                                   // EXEC
    bus.inst = $urandom;
    check({name, "_alu_a"}, bus.alu_a, ra);
    check({name, "_alu_b"}, bus.alu_b, rb);
    check({name, "_alu_op"}, 32'(bus.alu_op), 32'(code));
    check({name, "_exec_we"}, 32'(bus.rf_we), 32'd0);
    tick();                                   // WB
    bus.inst = $urandom;
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_illegal"}, 32'(bus.illegal), 32'(!legal));
    check({name, "_we"}, 32'(bus.rf_we), 32'(exp_we));
    check({name, "_waddr"}, 32'(bus.rf_waddr), 32'(rd));
    check({name, "_wdata"}, bus.rf_wdata, res);
    check({name, "_zf"}, 32'(bus.zf), 32'(z));
    check({name, "_of"}, 32'(bus.of), 32'(o));
    check({name, "_wb_ready"}, 32'(bus.inst_ready), 32'd0);
    $display("TXN %s inst=%08h rd=%0d wdata=%08h we=%0d zf=%0d of=%0d illegal=%0d",
             name, ins, rd, bus.rf_wdata, bus.rf_we, bus.zf, bus.of, bus.illegal);
    if (exp_we) ref_regs[rd] = res;
    tick();                                   // IDLE again
    check({name, "_post_done"}, 32'(bus.done), 32'd0);
    check({name, "_post_we"}, 32'(bus.rf_we), 32'd0);
    check({name, "_post_ready"}, 32'(bus.inst_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"},   32'(bus.inst_ready), 32'd1);
    check({name, "_done"},    32'(bus.done), 32'd0);
    check({name, "_illegal"}, 32'(bus.illegal), 32'd0);
    check({name, "_we"},      32'(bus.rf_we), 32'd0);
    check({name, "_zf"},      32'(bus.zf), 32'd0);
    check({name, "_of"},      32'(bus.of), 32'd0);
    check({name, "_waddr"},   32'(bus.rf_waddr), 32'd0);
    check({name, "_wdata"},   bus.rf_wdata, 32'd0);
    check({name, "_alu_a"},   bus.alu_a, 32'd0);
    check({name, "_alu_b"},   bus.alu_b, 32'd0);
    check({name, "_alu_op"},  32'(bus.alu_op), 32'd0);
    check({name, "_raddr1"},  32'(bus.rf_raddr1), 32'd0);
    check({name, "_raddr2"},  32'(bus.rf_raddr2), 32'd0);
  endtask

  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2a, F_SLLV = 6'h04;

  initial begin
    logic [5:0]  legal_fn [8];
    logic [5:0]  bad_fn [4];
    logic [31:0] ins;
    logic [31:0] old12;
    int          gap;

    legal_fn = '{F_AND, F_OR, F_XOR, F_NOR, F_ADD, F_SUB, F_SLT, F_SLLV};
    bad_fn   = '{6'h01, 6'h21, 6'h23, 6'h3f};

    rst = 1'b1; bus.inst = 32'd0; bus.inst_valid = 1'b0;
    load_en = 1'b0; load_addr = 5'd0; load_data = 32'd0;
    ref_regs[0] = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 1; i < 32; i++) load(5'(i), $urandom);

    // Basic ADD
    load(5'd1, 32'd5); load(5'd2, 32'd7);
    issue(rtype(F_ADD, 5'd3, 5'd1, 5'd2), 1'b0, "add_basic");
    check("add_basic_mem", mem[3], 32'd12);

    // SUB to zero, then dependent SLT
    issue(rtype(F_SUB, 5'd4, 5'd1, 5'd1), 1'b0, "sub_zero");
    issue(rtype(F_SLT, 5'd6, 5'd4, 5'd2), 1'b0, "slt_dep");
    check("slt_dep_mem", mem[6], 32'd1);

    // Overflow
    load(5'd7, 32'h7fff_ffff); load(5'd8, 32'd1);
    old12 = mem[5];
    issue(rtype(F_ADD, 5'd5, 5'd7, 5'd8), 1'b0, "add_ovf");
    check("add_ovf_mem", mem[5], TRAP_EN ? old12 : 32'h8000_0000);

    // Illegal opcode and rd=0
    issue({6'b100011, 5'd1, 5'd2, 5'd9, 5'd0, F_ADD}, 1'b0, "illegal_op");
    issue(rtype(F_OR, 5'd0, 5'd1, 5'd2), 1'b0, "or_rd0");

    // Back-to-back with inst_valid held high
    load(5'd9, 32'd4); load(5'd10, 32'd3);
    issue(rtype(F_SLLV, 5'd11, 5'd9, 5'd10), 1'b1, "b2b_sllv");
    issue(rtype(F_XOR, 5'd13, 5'd11, 5'd10), 1'b1, "b2b_xor");
    issue(rtype(F_NOR, 5'd14, 5'd13, 5'd2), 1'b0, "b2b_nor");
    check("b2b_sllv_mem", mem[11], 32'h30);

    // Reset during EXEC
    old12 = mem[12];
    bus.inst = rtype(F_ADD, 5'd12, 5'd1, 5'd2); bus.inst_valid = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
    tick();
    check("rst_mid_alu_op", 32'(bus.alu_op), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    check("rst_mid_mem", mem[12], old12);
    issue(rtype(F_ADD, 5'd12, 5'd1, 5'd2), 1'b0, "add_after_rst");

    // Randomized instructions with random idle gaps
    for (int n = 0; n < 40; n++) begin
      ins = rtype(legal_fn[$urandom_range(0, 7)], 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) ins[5:0] = bad_fn[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom_range(1, 63));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_done", 32'(bus.done), 32'd0);
      end
      issue(ins, 1'b0, $sformatf("rnd%0d", n));
    end

    for (int i = 1; i < 32; i++) check($sformatf("final_r%0d", i), mem[i], ref_regs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/writeback sequencer for the R-type CPU. It accepts one 32-bit R-type instruction at a time over a valid/ready handshake and decodes `funct` into the 3-bit ALU operation code. It reads the two source registers, drives the ALU operand and opcode ports, captures the result and flags, and writes the result back to the register file. It is the consumer side of the ALU interface: it produces `A`/`B`/`ALU_OP` and consumes `F`/`ZF`/`OF`.

## Interface
- No parameters; all widths are fixed at 32-bit data and 5-bit register addresses.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `inst` in 32: instruction word. Fields: `op=[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `rd=[15:11]`, `funct=[5:0]`.
- `inst_valid` in 1: `inst` is valid.
- `inst_ready` out 1: block can accept an instruction.
- `rf_raddr1`, `rf_raddr2` out 5: register-file read addresses (`rs`, `rt`).
- `rf_rdata1`, `rf_rdata2` in 32: combinational register-file read data.
- `rf_we` out 1: register-file write enable, one-cycle pulse.
- `rf_waddr` out 5: write address (`rd`).
- `rf_wdata` out 32: write data.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_op` out 3: ALU operation code.
- `alu_f` in 32: ALU result.
- `alu_zf` in 1: ALU zero flag.
- `alu_of` in 1: ALU overflow flag.
- `zf` out 1: zero flag of the last completed instruction.
- `of` out 1: overflow flag of the last completed instruction.
- `done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse, coincident with `done`, for an undecodable instruction.

## Operation
- **FSM states:** IDLE → READ → EXEC → WB → IDLE.
- **IDLE:**
  - `inst_ready=1`.
  - On `inst_valid & inst_ready`, latch `inst` into IR and go to READ.
  - Otherwise stay in IDLE.
- **READ:**
  - `rf_raddr1=IR.rs`, `rf_raddr2=IR.rt`.
  - At the edge, `rf_rdata1`/`rf_rdata2` are registered into operand registers A_q/B_q.
  - Go to EXEC.
- **EXEC:**
  - `alu_a=A_q`, `alu_b=B_q`, `alu_op` = decoded code.
  - At the edge, capture `alu_f` into R_q, `alu_zf` into `zf`, and `alu_of` into `of`.
  - Go to WB.
- **WB:**
  - `done=1`.
  - `rf_we=1` only when all of the following hold:
    - the instruction is legal;
    - `rd≠0`;
    - it is not a trapped overflow (see Configuration).
  - `rf_waddr=IR.rd`, `rf_wdata=R_q`.
  - Go to IDLE.
- **Decode.** Only `op=6'b000000` is legal. `funct` → `alu_op`:
  - `100100` AND → `000`
  - `100101` OR → `001`
  - `100110` XOR → `010`
  - `100111` NOR → `011`
  - `100000` ADD → `100`
  - `100010` SUB → `101`
  - `101010` SLT → `110`
  - `000100` SLLV → `111` (`alu_a=rs`, `alu_b=rt`, result is `rt<<rs`)
- **Illegal instructions.** Any other `op` or `funct`:
  - `alu_op=000`, the FSM still walks all states;
  - in WB: `illegal=1`, `rf_we=0`;
  - `zf`/`of` still update from the ALU outputs.
- **Idle outputs.** Outside EXEC, `alu_a`/`alu_b`/`alu_op` hold their last driven values. Outside READ, `rf_raddr*` hold their last driven values.
- **Reset values:**
  - state=IDLE;
  - IR, A_q, B_q, R_q all zero;
  - `zf=0`, `of=0`, `done=0`, `illegal=0`, `rf_we=0`;
  - `rf_waddr=0`, `rf_wdata=0`, `alu_a=0`, `alu_b=0`, `alu_op=000`, `rf_raddr*=0`.
- **Reset mid-operation.** `rst` in any state aborts the instruction:
  - no write occurs and no `done` is issued;
  - the next cycle is IDLE with `inst_ready=1`.

## Timing
- Handshake:
  - `inst_valid` may assert at any time. The instruction is accepted at the edge where `inst_valid & inst_ready`.
  - `inst` need not be held after acceptance.
  - `inst_ready=0` in READ, EXEC and WB.
- Latency: accepted at edge E0 → READ in E0..E1 → EXEC in E1..E2 → WB in E2..E3. `done`/`rf_we` are high in the cycle between E2 and E3.
- Throughput: one instruction per 4 cycles. `inst_ready` rises in the cycle after WB.
- Register-file timing:
  - the write occurs at edge E3;
  - a dependent next instruction reads in its own READ state (≥E4), so no forwarding is needed.
- The ALU is combinational. `alu_f`, `alu_zf` and `alu_of` are sampled only at the end of EXEC.

## Configuration
- Macro: `ALU_ISSUE_OVF_TRAP_EN`.
- **Defined:**
  - ADD/SUB with captured `of=1` suppresses `rf_we` in WB;
  - `illegal` stays 0;
  - `of=1` is visible with `done`.
- **Undefined:**
  - overflow results are written back normally;
  - `of` is still reported.

## Test plan
- **Basic ADD.** r1=5, r2=7, `inst` ADD rd=3 rs=1 rt=2.
  - `done` at cycle +3;
  - `rf_we=1`, `rf_waddr=3`, `rf_wdata=12`, `zf=0`, `of=0`.
- **SUB to zero, then dependent SLT.** SUB r1-r1 → rd=4.
  - Response: `rf_wdata=0`, `zf=1`.
  - Next: SLT r4<r2 → `rf_wdata=1`, i.e. the dependency is satisfied without stalls beyond the 4-cycle cadence.
- **Overflow.** ADD 0x7FFFFFFF + 1 → rd=5.
  - Macro defined: `of=1`, `rf_we=0`.
  - Macro undefined: `rf_we=1`, `rf_wdata=0x80000000`, `of=1`.
- **Illegal instruction and `rd=0`.**
  - `op=6'b100011` → `done=1`, `illegal=1`, `rf_we=0`.
  - Legal OR with `rd=0` → `done=1`, `rf_we=0`.
- **Back-to-back handshake and SLLV.**
  - Hold `inst_valid=1` continuously with a changing `inst`: accepts occur exactly every 4 cycles.
  - SLLV with rs=4, rt=0x3 gives `rf_wdata=0x30`.
- **Reset mid-operation.** Assert `rst` during EXEC.
  - No `rf_we` and no `done`;
  - all outputs are at reset values the next cycle;
  - `inst_ready=1`;
  - a following ADD completes normally.
